posit_decoder: RTL
==================

# posit_decoder

Sequential posit<N,ES> field decoder that sits directly upstream of the posit add/subtract stage. It accepts one packed posit word per handshake. Over a data-dependent number of cycles it unpacks the word into sign, special-value flags, combined scale and a hidden-bit-normalised fraction. The regime run length is counted serially, one bit per cycle, instead of with a wide leading-zero counter.

## Interface
- N, 32: posit word width.
- ES, 2: exponent field width.
- ap_clk  in  1: clock, rising edge.
- ap_rst_n  in  1: reset, asynchronous assert, active-low.
- in_valid  in  1: in_posit holds a word to decode.
- in_ready  out  1: block can accept a word; high only in IDLE.
- in_posit  in  N: packed posit.
- out_valid  out  1: decoded result is held stable.
- out_ready  in  1: consumer accepts the result.
- out_sign  out  1: sign of the original word (0 for zero and NaR).
- out_zero  out  1: input was all-zeros.
- out_nar  out  1: input was 1 followed by N-1 zeros.
- out_scale  out  SW=$clog2(N)+ES+2 (9): signed, k*2^ES + e.
- out_frac  out  FW+1 (28), FW=N-ES-3: {hidden 1, fraction left-justified, zero-padded}; 0 for zero/NaR.

## Operation
- States: IDLE, ABS, SCAN, EXTRACT, DONE.
- IDLE, accept (in_valid && in_ready):
  - capture in_posit.
  - all-zeros: out_zero=1, go to DONE.
  - 1 followed by N-1 zeros: out_nar=1, go to DONE.
  - otherwise go to ABS.
- ABS:
  - out_sign = word[N-1].
  - body register sr = (sign ? -word : word)[N-2:0].
  - r0 = sr MSB; cnt = 0.
- SCAN:
  - each cycle: cnt++, sr <<= 1 (zero fill).
  - leave for EXTRACT once the next bit differs from r0, or once cnt reaches N-1.
  - m = final cnt = regime run length, 1..N-1.
- EXTRACT:
  - drop the terminator bit (if one exists).
  - e = next ES bits of sr, zero-padded if the word runs out.
  - fraction = next FW bits of sr, zero-padded.
  - k = r0 ? m-1 : -m.
  - out_scale = k*2^ES + e.
  - out_frac = {1'b1, fraction}.
  - go to DONE.
- DONE:
  - out_valid=1; all outputs held stable.
  - on out_ready: go to IDLE, clear out_valid.
  - in the same cycle the flags are cleared only at the next accept.
- Scale range is ±(N-2)*2^ES (±120) and must fit SW without overflow.
- Sign is applied before the regime scan, so negative inputs decode to magnitude fields plus out_sign=1.

## Timing
- Reset (async, ap_rst_n=0):
  - state=IDLE, in_ready=1 after release.
  - out_valid, out_sign, out_zero, out_nar = 0.
  - out_scale, out_frac = 0.
  - sr, cnt = 0.
- Reset asserted mid-operation aborts the decode immediately; no partial result is ever presented.
- Latency, counted from the accept edge to the first edge with out_valid high:
  - zero/NaR: 1 cycle.
  - normal: m+3 cycles (ABS 1, SCAN m, EXTRACT 1, then DONE).
- Worst case is m=N-1, i.e. 34 cycles.
- No pipelining.
  - in_ready is low from the accept edge until DONE is left.
  - back-to-back throughput is one word per latency+1 cycles when out_ready is held high.
- out_ready low in DONE stalls indefinitely with outputs frozen.
- in_valid outside IDLE is ignored; in_posit is not sampled.
- out_ready outside DONE has no effect.

## Structure
- Shared package posit_pkg holds:
  - localparams N, ES, FW, SW;
  - the state enum {IDLE, ABS, SCAN, EXTRACT, DONE};
  - the NaR constant (1 followed by N-1 zeros).
- The add/subtract stage imports the same package.
- Single module, no sub-module; the datapath is one shift register, one counter and the scale adder.

## Test plan
- 0x40000000 (1.0) → after 4 cycles: sign 0, scale 0, frac 0x8000000, zero/nar 0.
- 0x0C12A006 → m=3, k=-3, e=2; after 6 cycles: scale -10, frac 0x84A8018, sign 0.
- 0xC0000000 (-1.0) → sign 1, scale 0, frac 0x8000000.
- 0x7FFFFFFF → m=31, latency 34, scale +120, frac 0x8000000.
- 0x00000001 → m=30, latency 33, scale -120, frac 0x8000000.
- 0x00000000 → out_zero=1 after 1 cycle.
- 0x80000000 → out_nar=1 after 1 cycle, frac 0, scale 0.
- Stall/reset:
  - hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0.
  - assert ap_rst_n=0 during SCAN → all outputs 0 at once; the next word decodes correctly.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit<N,ES> definitions used by the field decoder and the
// downstream add/subtract stage.
//   N, ES : posit word width and exponent field width
//   FW    : fraction bits carried after the hidden bit
//   SW    : signed scale width, wide enough for +/-(N-2)*2^ES
//   CW    : regime run-length counter width (holds 1..N-1)
//   NAR   : Not-a-Real pattern, 1 followed by N-1 zeros
package posit_pkg;

  localparam int N  = 32;
  localparam int ES = 2;
  localparam int FW = N - ES - 3;
  localparam int SW = $clog2(N) + ES + 2;
  localparam int CW = $clog2(N);

  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    SCAN,
    EXTRACT,
    DONE
  } state_t;

endpackage

// File: rtl/posit_decoder_if.sv
// Handshake bundle between a posit word producer, the decoder and the
// consumer of the decoded fields.
//   in_valid/in_ready/in_posit : packed posit word, valid/ready handshake
//   out_valid/out_ready        : decoded result handshake
//   out_sign/out_zero/out_nar  : sign and special-value flags
//   out_scale                  : signed k*2^ES + e
//   out_frac                   : {hidden 1, fraction left-justified}
// master drives words and accepts results; slave is the decoder.
interface posit_decoder_if;
  import posit_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_posit;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic                 out_zero;
  logic                 out_nar;
  logic signed [SW-1:0] out_scale;
  logic [FW:0]          out_frac;

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_nar, out_scale, out_frac
  );

  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_nar, out_scale, out_frac
  );

endinterface

// File: rtl/posit_decoder.sv
// Sequential posit<N,ES> field decoder. One word is accepted in IDLE,
// its magnitude taken in ABS, the regime run counted one bit per cycle
// in SCAN, exponent/fraction sliced and scale formed in EXTRACT, and the
// result held in DONE until the consumer takes it.
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset; aborts any decode in flight
//   bus      : posit_decoder_if slave (word in, decoded fields out)
module posit_decoder
  import posit_pkg::*;
(
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  posit_decoder_if.slave  bus
);

  state_t               state_q, state_d;
  logic [N-1:0]         word_q;
  logic [N-2:0]         sr_q;
  logic [CW-1:0]        cnt_q;
  logic                 r0_q;
  logic                 sign_q, zero_q, nar_q;
  logic signed [SW-1:0] scale_q;
  logic [FW:0]          frac_q;

  logic                 accept;
  logic [N-1:0]         abs_word;
  logic [N-2:0]         sr_shl;
  logic [CW-1:0]        cnt_inc;
  logic                 scan_stop;
  logic [ES-1:0]        exp_bits;
  logic [FW-1:0]        frac_bits;
  logic signed [SW-1:0] cnt_s, k_val, scale_val;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign abs_word = word_q[N-1] ? -word_q : word_q;
  assign sr_shl   = {sr_q[N-3:0], 1'b0};
  assign cnt_inc  = cnt_q + 1'b1;

  // The bit that becomes MSB after this shift is the candidate terminator;
  // a run covering the whole body ends on the count alone.
  assign scan_stop = (sr_shl[N-2] != r0_q) || (cnt_inc == CW'(N - 1));

  // After m shifts sr[N-2] is the terminator, so exponent and fraction
  // follow directly below it. A run with no terminator has shifted every
  // body bit out, leaving zeros here, which is the required padding.
  assign exp_bits  = sr_q[N-3 -: ES];
  assign frac_bits = sr_q[N-3-ES -: FW];

  assign cnt_s     = signed'(SW'(cnt_q));
  assign k_val     = r0_q ? (cnt_s - SW'(1)) : -cnt_s;
  assign scale_val = (k_val <<< ES) + signed'(SW'(exp_bits));

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if ((bus.in_posit == '0) || (bus.in_posit == NAR)) state_d = DONE;
          else                                               state_d = ABS;
        end
      end
      ABS:     state_d = SCAN;
      SCAN:    if (scan_stop) state_d = EXTRACT;
      EXTRACT: state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // NOTE: all datapath registers reset so an aborted decode never leaves a
  // stale partial result visible on the outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      word_q  <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      r0_q    <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      nar_q   <= 1'b0;
      scale_q <= '0;
      frac_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Result fields stay visible after DONE and clear only here.
          if (accept) begin
            word_q  <= bus.in_posit;
            sign_q  <= 1'b0;
            zero_q  <= (bus.in_posit == '0);
            nar_q   <= (bus.in_posit == NAR);
            scale_q <= '0;
            frac_q  <= '0;
          end
        end
        ABS: begin
          sign_q <= word_q[N-1];
          sr_q   <= abs_word[N-2:0];
          r0_q   <= abs_word[N-2];
          cnt_q  <= '0;
        end
        SCAN: begin
          cnt_q <= cnt_inc;
          sr_q  <= sr_shl;
        end
        EXTRACT: begin
          scale_q <= scale_val;
          frac_q  <= {1'b1, frac_bits};
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sign  = sign_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_nar   = nar_q;
  assign bus.out_scale = scale_q;
  assign bus.out_frac  = frac_q;

endmodule
